// File: rtl/led_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_sequencer
// Description : Turns rising edges of a slow divided-clock level into one-cycle
//               step pulses. Each step advances an LED pattern in one of four
//               modes: BLINK, CHASE, BOUNCE and BINARY. The pattern can be
//               paused, and the mode can be changed while running.
//               Optional feature macro: LED_PWM_EN. When it is defined, the
//               module gains a brightness[7:0] input and the LED bank is
//               dimmed by a free-running 8-bit PWM counter.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_sequencer #(
    parameter int NUM_LEDS    = 8,   // 2..16
    parameter int SYNC_STAGES = 2    // 2..3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tick_in,
    input  logic [1:0]          mode,
    input  logic                pause,
`ifdef LED_PWM_EN
    input  logic [7:0]          brightness,
`endif
    output logic [NUM_LEDS-1:0] leds,
    output logic [15:0]         step_count
);

    localparam logic [1:0] C_MODE_BLINK  = 2'b00;
    localparam logic [1:0] C_MODE_CHASE  = 2'b01;
    localparam logic [1:0] C_MODE_BOUNCE = 2'b10;
    localparam logic [1:0] C_MODE_BINARY = 2'b11;

    localparam logic [NUM_LEDS-1:0] C_ONE = {{(NUM_LEDS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Tick synchronizer and rising-edge detector
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   sync_out;
    logic                   step_pulse;

    assign sync_out   = sync_q[SYNC_STAGES-1];
    assign step_pulse = sync_out & ~hist_q;

    // Shift tick_in through the synchronizer and keep one history bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
            hist_q <= sync_out;
        end
    end

    // ------------------------------------------------------------------------
    // Mode register and change flag
    // ------------------------------------------------------------------------
    logic [1:0] mode_q;
    logic       chg_q;
    logic       chg_d;
    logic       step_consumed;

    // A change seen in the same cycle a step is consumed must survive. That
    // step still runs in the old mode, and the new mode loads on the next step.
    always_comb begin
        chg_d = (chg_q & ~step_consumed) | (mode != mode_q);
    end

    // Register the mode every clock and track pending mode changes.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q <= C_MODE_BLINK;
            chg_q  <= 1'b0;
        end else begin
            mode_q <= mode;
            chg_q  <= chg_d;
        end
    end

    // ------------------------------------------------------------------------
    // Pattern helpers
    // ------------------------------------------------------------------------
    function automatic logic [NUM_LEDS-1:0] start_pattern(input logic [1:0] m);
        logic [NUM_LEDS-1:0] p;
        case (m)
            C_MODE_BLINK:  p = '1;
            C_MODE_CHASE:  p = C_ONE;
            C_MODE_BOUNCE: p = C_ONE;
            default:       p = '0;
        endcase
        return p;
    endfunction

    logic [NUM_LEDS-1:0] pattern_q;
    logic [NUM_LEDS-1:0] pattern_d;
    logic [NUM_LEDS-1:0] pat_adv;
    logic                dir_down_q;
    logic                dir_down_d;
    logic                dir_adv;

    // Compute the next pattern in the current mode. BOUNCE turns around
    // when it lands on an end bit, so the end LED is shown only once.
    always_comb begin
        pat_adv = pattern_q;
        dir_adv = dir_down_q;
        case (mode_q)
            C_MODE_BLINK: begin
                pat_adv = ~pattern_q;
            end
            C_MODE_CHASE: begin
                pat_adv = {pattern_q[NUM_LEDS-2:0], pattern_q[NUM_LEDS-1]};
            end
            C_MODE_BOUNCE: begin
                if (!dir_down_q) begin
                    pat_adv = pattern_q << 1;
                    if (pat_adv[NUM_LEDS-1]) begin
                        dir_adv = 1'b1;
                    end
                end else begin
                    pat_adv = pattern_q >> 1;
                    if (pat_adv[0]) begin
                        dir_adv = 1'b0;
                    end
                end
            end
            default: begin
                pat_adv = pattern_q + C_ONE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------------
    state_t      state_q;
    state_t      state_d;
    logic [15:0] count_q;
    logic [15:0] count_d;

    // Next-state logic. A step that arrives while pause is high, or in the
    // cycle that leaves PAUSED, is dropped rather than queued.
    always_comb begin
        state_d       = state_q;
        pattern_d     = pattern_q;
        dir_down_d    = dir_down_q;
        count_d       = count_q;
        step_consumed = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (step_pulse && !pause) begin
                    state_d       = ST_RUN;
                    pattern_d     = start_pattern(mode_q);
                    dir_down_d    = 1'b0;
                    count_d       = 16'd1;
                    step_consumed = 1'b1;
                end
            end
            ST_RUN: begin
                if (pause) begin
                    state_d = ST_PAUSED;
                end else if (step_pulse) begin
                    step_consumed = 1'b1;
                    count_d       = count_q + 16'd1;
                    if (chg_q) begin
                        pattern_d  = start_pattern(mode_q);
                        dir_down_d = 1'b0;
                    end else begin
                        pattern_d  = pat_adv;
                        dir_down_d = dir_adv;
                    end
                end
            end
            ST_PAUSED: begin
                if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register the FSM state, pattern, bounce direction and step counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pattern_q  <= '0;
            dir_down_q <= 1'b0;
            count_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            pattern_q  <= pattern_d;
            dir_down_q <= dir_down_d;
            count_q    <= count_d;
        end
    end

    assign step_count = count_q;

    // ------------------------------------------------------------------------
    // LED output stage
    // ------------------------------------------------------------------------
`ifdef LED_PWM_EN
    logic [7:0] pwm_q;

    // Free-running PWM counter. It keeps running in every FSM state.
    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_q <= 8'd0;
        end else begin
            pwm_q <= pwm_q + 8'd1;
        end
    end

    assign leds = pattern_q & {NUM_LEDS{(pwm_q < brightness)}};
`else
    assign leds = pattern_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pattern_sequencer
// Description : Directed self-checking bench for led_pattern_sequencer.
//               It also exercises brightness when LED_PWM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        tick_in;
    logic [1:0]  mode;
    logic        pause;
    logic [7:0]  leds;
    logic [15:0] step_count;
`ifdef LED_PWM_EN
    logic [7:0]  brightness;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    led_pattern_sequencer #(
        .NUM_LEDS    (8),
        .SYNC_STAGES (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tick_in    (tick_in),
        .mode       (mode),
        .pause      (pause),
`ifdef LED_PWM_EN
        .brightness (brightness),
`endif
        .leds       (leds),
        .step_count (step_count)
    );

    always #5 clock = ~clock;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full tick period: 50 cycles high, then 50 cycles low. Returns #1 after an edge.
    task automatic step_once();
        tick_in = 1'b1;
        repeat (50) @(posedge clock);
        #1 tick_in = 1'b0;
        repeat (50) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    logic [7:0] bounce_exp [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                   8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] c0;
        int          on_cnt;
        int          nz_cnt;

        reset   = 1'b1;
        tick_in = 1'b0;
        pause   = 1'b0;
        mode    = 2'b00;
`ifdef LED_PWM_EN
        brightness = 8'hFF;
`endif
        repeat (2) @(posedge clock);
        #1;
        check("reset_leds",  32'(leds),       32'h0);
        check("reset_count", 32'(step_count), 32'h0);
        reset = 1'b0;
        mode  = 2'b01;
        @(posedge clock);
        #1;

        // Test 1: CHASE, 10 steps
        for (int i = 0; i < 10; i++) begin
            step_once();
            check($sformatf("chase_%0d", i), 32'(leds), 32'(1 << (i % 8)));
        end
        check("chase_count", 32'(step_count), 32'd10);

        // Test 2: edge latency and single pulse for a long high level
        c0 = step_count;
        tick_in = 1'b1;
        repeat (2) @(posedge clock);
        #1 check("lat_before", 32'(step_count), 32'(c0));
        @(posedge clock);
        #1 check("lat_at", 32'(step_count), 32'(c0 + 16'd1));
        repeat (500) @(posedge clock);
        #1 check("lat_hold", 32'(step_count), 32'(c0 + 16'd1));
        tick_in = 1'b0;
        repeat (50) @(posedge clock);
        #1;

        // Test 3: BOUNCE via mode change, 16 steps
        mode = 2'b10;
        for (int i = 0; i < 16; i++) begin
            step_once();
            check($sformatf("bounce_%0d", i), 32'(leds), 32'(bounce_exp[i]));
        end

        // Test 4: pause in BINARY. The start value 0 takes the first step,
        // so seven steps end at 6.
        do_reset();
        mode = 2'b11;
        repeat (5) step_once();
        check("bin_pre_leds",  32'(leds),       32'h04);
        check("bin_pre_count", 32'(step_count), 32'd5);
        pause = 1'b1;
        repeat (3) step_once();
        check("pause_leds",  32'(leds),       32'h04);
        check("pause_count", 32'(step_count), 32'd5);
        pause = 1'b0;
        repeat (2) step_once();
        check("resume_leds",  32'(leds),       32'h06);
        check("resume_count", 32'(step_count), 32'd7);

        // Test 5: BINARY -> BLINK at 0x05, then a mid-run reset
        do_reset();
        mode = 2'b11;
        repeat (6) step_once();
        check("bin_at5", 32'(leds), 32'h05);
        mode = 2'b00;
        step_once();
        check("blink_load", 32'(leds), 32'hFF);
        step_once();
        check("blink_inv", 32'(leds), 32'h00);
        step_once();
        check("blink_inv2", 32'(leds), 32'hFF);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midrst_leds",  32'(leds),       32'h0);
        check("midrst_count", 32'(step_count), 32'h0);

        // tick_in already high when reset is released gives exactly one step
        tick_in = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        check("rst_high_count", 32'(step_count), 32'd1);
        check("rst_high_leds",  32'(leds),       32'hFF);
        tick_in = 1'b0;
        repeat (20) @(posedge clock);
        #1;

        // pause held while IDLE keeps the FSM idle
        do_reset();
        pause = 1'b1;
        step_once();
        check("idle_pause_count", 32'(step_count), 32'd0);
        check("idle_pause_leds",  32'(leds),       32'h0);
        pause = 1'b0;
        step_once();
        check("idle_exit_count", 32'(step_count), 32'd1);

`ifdef LED_PWM_EN
        // Test 6: PWM duty, with the BLINK start pattern 0xFF on the LEDs
        do_reset();
        mode = 2'b00;
        step_once();
        brightness = 8'h40;
        repeat (4) @(posedge clock);
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clock);
            if (leds == 8'hFF) on_cnt++;
        end
        check("pwm_duty_40", 32'(on_cnt), 32'd64);
        brightness = 8'h00;
        nz_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (leds != 8'h00) nz_cnt++;
        end
        check("pwm_zero", 32'(nz_cnt), 32'd0);
`else
        on_cnt = 0;
        nz_cnt = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
